// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//  Shared definitions for the MIPS fetch-side blocks.
//  - DEFAULT_REG_LEN : default instruction / address width
//  - NOP_INST        : all-zero instruction word that is returned for faulting fetches
//  - imem_state_e    : state encoding of the instruction-memory responder FSM
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int DEFAULT_REG_LEN = 32;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef enum logic {
        IMEM_IDLE = 1'b0,
        IMEM_WAIT = 1'b1
    } imem_state_e;

endpackage

// File: rtl/imem_array.sv
// ---------------------------------------------------------------------------
// imem_array
//  WORDS x WIDTH program storage with one synchronous read port and one
//  write port. A read and a write to the same word on the same edge return
//  the word as it was before the write (read-old-data).
//  Ports:
//   clk      in  clock, all accesses on the rising edge
//   rd_en    in  read strobe; rd_data only changes on a strobed edge
//   rd_addr  in  word index to read
//   rd_data  out registered read data
//   wr_en    in  write strobe
//   wr_addr  in  word index to write
//   wr_data  in  data to write
// ---------------------------------------------------------------------------
module imem_array #(
    parameter int WORDS = 1024,
    parameter int WIDTH = 32,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data
);

    logic [WIDTH-1:0] mem [WORDS];

    // Both ports use non-blocking updates on the same edge, so a colliding
    // read picks up the stored value from before this edge's write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/imem_responder.sv
// ---------------------------------------------------------------------------
// imem_responder
//  Instruction-memory responder for the IF stage. A fetch accepted in cycle T
//  completes in cycle T+LATENCY (memory read issued) and is presented as a
//  one-cycle inst_valid pulse in cycle T+LATENCY+1. stall_out holds the PC
//  while the fetch is outstanding. flush discards the in-flight fetch.
//  A loader port writes program memory at any time.
//  Ports:
//   clk, rst    clock and synchronous active-high reset
//   req         fetch request, inst_addr is a byte address
//   flush       control-flow redirect, aborts the current fetch
//   wr_en       loader write strobe with wr_addr (byte address) / wr_data
//   inst_out    fetched instruction, holds between responses
//   inst_valid  one-cycle response pulse
//   fault       misaligned / out-of-range fetch, qualified by inst_valid
//   stall_out   hold-PC request to the IF stage
// ---------------------------------------------------------------------------
module imem_responder
    import mips_pkg::*;
#(
    parameter int REG_LEN   = DEFAULT_REG_LEN,
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic [REG_LEN-1:0] inst_addr,
    input  logic               flush,
    input  logic               wr_en,
    input  logic [REG_LEN-1:0] wr_addr,
    input  logic [REG_LEN-1:0] wr_data,
    output logic [REG_LEN-1:0] inst_out,
    output logic               inst_valid,
    output logic               fault,
    output logic               stall_out
);

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int CW = 4;
    localparam logic [CW-1:0]      CNT_LOAD   = (LATENCY > 0) ? CW'(LATENCY - 1) : '0;
    localparam logic [REG_LEN-3:0] WORD_LIMIT = (REG_LEN - 2)'(MEM_WORDS);

    imem_state_e        state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [REG_LEN-1:0] addr_q, addr_n;
    logic [REG_LEN-1:0] cur_addr;
    logic               fetch_fault;
    logic               complete;
    logic               stall_c;
    logic               rd_en;
    logic               wr_ok;
    logic [REG_LEN-1:0] rd_data;
    logic               out_is_nop;
    logic [1:0]         unused_wr_low;

    // Loader writes are word-granular; the byte offset carries no meaning.
    assign unused_wr_low = wr_addr[1:0];

    // In IDLE the fetch address comes straight from the PC so a zero-latency
    // fetch can complete in its accept cycle; afterwards the latched copy is used.
    assign cur_addr    = (state == IMEM_IDLE) ? inst_addr : addr_q;
    assign fetch_fault = (cur_addr[1:0] != 2'b00) || (cur_addr[REG_LEN-1:2] >= WORD_LIMIT);

    // Faulting fetches never touch the array, and an aborted completion must
    // leave the previous read data in place so inst_out keeps holding.
    assign rd_en = complete && !fetch_fault && !rst;
    assign wr_ok = wr_en && (wr_addr[REG_LEN-1:2] < WORD_LIMIT);

    imem_array #(
        .WORDS (MEM_WORDS),
        .WIDTH (REG_LEN),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .rd_en   (rd_en),
        .rd_addr (cur_addr[AW+1:2]),
        .rd_data (rd_data),
        .wr_en   (wr_ok),
        .wr_addr (wr_addr[AW+1:2]),
        .wr_data (wr_data)
    );

    // Next-state logic. "complete" marks the cycle in which the memory word
    // is read; the response becomes visible one cycle later.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        addr_n   = addr_q;
        complete = 1'b0;
        stall_c  = 1'b0;
        case (state)
            IMEM_IDLE: begin
                if (req && !flush) begin
                    addr_n = inst_addr;
                    if (LATENCY == 0) begin
                        complete = 1'b1;
                    end else begin
                        state_n = IMEM_WAIT;
                        cnt_n   = CNT_LOAD;
                        stall_c = 1'b1;
                    end
                end
            end
            IMEM_WAIT: begin
                stall_c = (cnt != '0);
                if (flush) begin
                    state_n = IMEM_IDLE;
                    cnt_n   = '0;
                end else if (cnt == '0) begin
                    complete = 1'b1;
                    state_n  = IMEM_IDLE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: begin
                state_n = IMEM_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign stall_out = stall_c && !rst;

    // State and response registers. out_is_nop selects the NOP constant on
    // inst_out; reset sets it so inst_out reads zero until the first real fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IMEM_IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            inst_valid <= 1'b0;
            fault      <= 1'b0;
            out_is_nop <= 1'b1;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            addr_q     <= addr_n;
            inst_valid <= complete;
            fault      <= complete && fetch_fault;
            if (complete) begin
                out_is_nop <= fetch_fault;
            end
        end
    end

    assign inst_out = out_is_nop ? REG_LEN'(NOP_INST) : rd_data;

endmodule

// File: tb/tb_imem_responder.sv
// ---------------------------------------------------------------------------
// tb_imem_responder
//  Drives three responders (LATENCY 0, 2, 3) with identical stimulus. A
//  fetch-level reference model queues the expected responses per instance;
//  a negedge monitor pops and compares whenever inst_valid is seen.
// ---------------------------------------------------------------------------
module tb_imem_responder;

    localparam int NDUT      = 3;
    localparam int MEM_WORDS = 1024;

    function automatic int lat_of(input int g);
        case (g)
            0:       return 0;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        flt;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst, req, flush, wr_en;
    logic [31:0] inst_addr, wr_addr, wr_data;
    logic [31:0] inst_out   [NDUT];
    logic        inst_valid [NDUT];
    logic        fault      [NDUT];
    logic        stall_out  [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        imem_responder #(
            .REG_LEN   (32),
            .MEM_WORDS (MEM_WORDS),
            .LATENCY   (lat_of(g))
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .req        (req),
            .inst_addr  (inst_addr),
            .flush      (flush),
            .wr_en      (wr_en),
            .wr_addr    (wr_addr),
            .wr_data    (wr_data),
            .inst_out   (inst_out[g]),
            .inst_valid (inst_valid[g]),
            .fault      (fault[g]),
            .stall_out  (stall_out[g])
        );
    end

    // Reference model state
    logic [31:0] model_mem [MEM_WORDS];
    rsp_t        expq      [NDUT][$];
    int          pend_end  [NDUT] = '{-1, -1, -1};
    logic [31:0] pend_addr [NDUT];
    logic        exp_stall [NDUT] = '{1'b0, 1'b0, 1'b0};
    logic [31:0] hold      [NDUT] = '{32'h0, 32'h0, 32'h0};

    int   cyc      = 0;
    int   n_cmp    = 0;
    int   n_err    = 0;
    bit   mon_en   = 1'b0;
    logic prev_rst = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Response that a fetch of byte address a produces from the current model memory.
    function automatic rsp_t model_read(input logic [31:0] a, input int due);
        rsp_t e;
        e.due = due;
        if (a[1:0] != 2'b00 || int'(a[31:2]) >= MEM_WORDS) begin
            e.data = 32'h0;
            e.flt  = 1'b1;
        end else begin
            e.data = model_mem[a[11:2]];
            e.flt  = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("[TB] FAIL %s dut%0d cyc=%0d: got %h, expected %h", name, g, cyc, act, want);
        end
    endtask

    // One clock cycle of stimulus; the model advances each instance by the same cycle.
    task automatic apply_stimulus(input logic r, input logic [31:0] a, input logic f,
                                  input logic we, input logic [31:0] wa, input logic [31:0] wd,
                                  input logic rs);
        @(posedge clk);
        #1;
        req = r; inst_addr = a; flush = f;
        wr_en = we; wr_addr = wa; wr_data = wd; rst = rs;
        for (int g = 0; g < NDUT; g++) begin
            exp_stall[g] = 1'b0;
            if (rs) begin
                pend_end[g] = -1;
            end else if (pend_end[g] >= cyc) begin
                exp_stall[g] = (cyc < pend_end[g]);
                if (f) begin
                    pend_end[g] = -1;
                end else if (cyc == pend_end[g]) begin
                    expq[g].push_back(model_read(pend_addr[g], cyc + 1));
                    pend_end[g] = -1;
                end
            end else if (r && !f) begin
                if (lat_of(g) == 0) begin
                    expq[g].push_back(model_read(a, cyc + 1));
                end else begin
                    pend_end[g]  = cyc + lat_of(g);
                    pend_addr[g] = a;
                    exp_stall[g] = 1'b1;
                end
            end
        end
        if (we && int'(wa[31:2]) < MEM_WORDS) model_mem[wa[11:2]] = wd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic fetch(input logic [31:0] a);
        apply_stimulus(1'b1, a, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic check_output();
        rsp_t e;
        for (int g = 0; g < NDUT; g++) begin
            chk("stall_out", g, 32'(stall_out[g]), 32'(exp_stall[g]));
            if (prev_rst) begin
                chk("valid_after_rst", g, 32'(inst_valid[g]), 32'h0);
                chk("fault_after_rst", g, 32'(fault[g]), 32'h0);
                hold[g] = 32'h0;
            end else if (inst_valid[g] === 1'b1) begin
                if (expq[g].size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("[TB] FAIL unexpected_valid dut%0d cyc=%0d: got inst_valid=1, expected 0", g, cyc);
                end else begin
                    e = expq[g].pop_front();
                    chk("resp_cycle", g, 32'(cyc), 32'(e.due));
                    chk("inst_out", g, inst_out[g], e.data);
                    chk("fault", g, 32'(fault[g]), 32'(e.flt));
                    hold[g] = e.data;
                end
            end else begin
                chk("fault_idle", g, 32'(fault[g]), 32'h0);
                if (expq[g].size() != 0 && expq[g][0].due <= cyc) begin
                    e = expq[g].pop_front();
                    n_cmp++;
                    n_err++;
                    $display("[TB] FAIL missing_valid dut%0d cyc=%0d: got no response, expected one due at %0d", g, cyc, e.due);
                end
            end
            chk("inst_out_hold", g, inst_out[g], hold[g]);
        end
        prev_rst = rst;
    endtask

    always @(negedge clk) if (mon_en) check_output();

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic        r, f, we, rs;
        logic [31:0] a, wa;
        int          kind;

        req = 1'b0; inst_addr = '0; flush = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rst = 1'b1;

        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        mon_en = 1'b1;

        // Fill program memory, then plant the directed-test word.
        for (int i = 0; i < MEM_WORDS; i++)
            apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 32'h2002_0005, 1'b0);
        idle(2);

        $display("[TB] single fetch of 0x100");
        fetch(32'h100);
        idle(6);

        $display("[TB] back-to-back sequential fetches");
        fetch(32'h0); fetch(32'h4); fetch(32'h8);
        idle(6);

        $display("[TB] flush after accept, then new fetch");
        fetch(32'h40);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        fetch(32'h44);
        idle(8);

        $display("[TB] misaligned and out-of-range fetches");
        fetch(32'h102);
        idle(5);
        fetch(32'h1000);
        idle(5);

        $display("[TB] loader write colliding with completion read");
        fetch(32'h100);
        idle(1);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0);
        idle(5);
        fetch(32'h100);
        idle(5);

        $display("[TB] reset while busy");
        fetch(32'h80);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        idle(1);
        fetch(32'h84);
        idle(6);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            r    = ($urandom_range(0, 2) != 0);
            kind = $urandom_range(0, 9);
            if (kind == 0)      a = 32'($urandom_range(0, 255) * 4 + $urandom_range(1, 3));
            else if (kind == 1) a = 32'h1000 + 32'($urandom_range(0, 4095) * 4);
            else                a = 32'($urandom_range(0, 63) * 4);
            f  = ($urandom_range(0, 9) == 0);
            we = ($urandom_range(0, 3) == 0);
            wa = ($urandom_range(0, 7) == 0) ? 32'h1000 + 32'($urandom_range(0, 63) * 4)
                                             : 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
            rs = ($urandom_range(0, 59) == 0);
            apply_stimulus(r, a, f, we, wa, $urandom, rs);
        end
        idle(10);

        for (int g = 0; g < NDUT; g++) begin
            n_cmp++;
            if (expq[g].size() != 0) begin
                n_err++;
                $display("[TB] FAIL leftover_responses dut%0d: got %0d outstanding, expected 0", g, expq[g].size());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
